// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared types and constants for the alu_md integer ALU / multiply / divide block.
//   alu_op_e  : 5-bit operation code
//   state_e   : control FSM state
//   result constants for illegal opcodes and divide-by-zero quotients
package alu_md_pkg;

  typedef enum logic [4:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpSll    = 5'd2,
    OpSlt    = 5'd3,
    OpSltu   = 5'd4,
    OpXor    = 5'd5,
    OpSrl    = 5'd6,
    OpSra    = 5'd7,
    OpOr     = 5'd8,
    OpAnd    = 5'd9,
    OpMul    = 5'd10,
    OpMulh   = 5'd11,
    OpMulhsu = 5'd12,
    OpMulhu  = 5'd13,
    OpDiv    = 5'd14,
    OpDivu   = 5'd15,
    OpRem    = 5'd16,
    OpRemu   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Sliced down to WIDTH by the users.
  localparam logic [63:0] ILLEGAL_RESULT    = '0;
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  function automatic logic is_mul_op(logic [4:0] op);
    return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) || (op == OpMulhu);
  endfunction

  function automatic logic is_div_op(logic [4:0] op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: request/response bundle of the alu_md block.
//   i_valid/o_ready  request handshake        i_flush      abort in-flight operation
//   i_alu_op         opcode (alu_md_pkg)      i_operand_a/b source operands
//   o_valid          result pulse             o_alu_data   registered result
//   o_busy           iterative op running
// modport slave is the ALU side, modport master the requester side.
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic             i_flush;
  logic [4:0]       i_alu_op;
  logic [WIDTH-1:0] i_operand_a;
  logic [WIDTH-1:0] i_operand_b;
  logic             o_valid;
  logic [WIDTH-1:0] o_alu_data;
  logic             o_busy;

  modport slave (
    input  i_valid, i_flush, i_alu_op, i_operand_a, i_operand_b,
    output o_ready, o_valid, o_alu_data, o_busy
  );

  modport master (
    output i_valid, i_flush, i_alu_op, i_operand_a, i_operand_b,
    input  o_ready, o_valid, o_alu_data, o_busy
  );
endinterface

// File: rtl/alu_md_div.sv
// alu_md_div: iterative restoring divider, one quotient bit per cycle for WIDTH cycles.
//   i_clk, i_rst_n      clock, async active-low reset
//   i_start             capture operands and begin (ignored while i_flush=1)
//   i_flush             abandon the current division
//   i_signed            treat operands as two's complement
//   i_dividend/divisor  operands, sampled with i_start
//   o_done              high in the last iteration cycle; results valid alongside it
//   o_quotient/o_remainder  final, sign-corrected results (combinational, valid with o_done)
module alu_md_div
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;      // holds the remaining dividend bits, quotient shifts in below
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  assign w_a_neg = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg = i_signed & i_divisor[WIDTH-1];
  assign w_mag_a = w_a_neg ? -i_dividend : i_dividend;
  assign w_mag_b = w_b_neg ? -i_divisor : i_divisor;

  // Restoring step: keep the subtraction only if it did not go negative.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  assign o_done = r_active & w_last;

  // Signed overflow (most-negative / -1) falls out of the magnitude path naturally;
  // divide-by-zero needs an override because the sign fix-up would corrupt it.
  always_comb begin
    o_quotient  = r_neg_q ? -w_quo_next : w_quo_next;
    o_remainder = r_neg_r ? -w_rem_next : w_rem_next;
    if (r_div_zero) begin
      o_quotient  = DIV_ZERO_QUOTIENT[WIDTH-1:0];
      o_remainder = r_dividend;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (i_flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= w_mag_a;
      r_dvs      <= w_mag_b;
      r_dividend <= i_dividend;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_div_zero <= (i_divisor == '0);
    end else if (r_active) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// alu_md: integer ALU with iterative shift-add multiplier and optional restoring divider.
//   i_clk    clock (rising edge)
//   i_rst_n  async active-low reset
//   bus      alu_md_if.slave: i_valid/o_ready request, i_flush, i_alu_op, i_operand_a/b,
//            o_valid result pulse, o_alu_data, o_busy
// Build option: define ALU_MD_DIV_EN to include the divider (opcodes 14-17); without it those
// opcodes behave as illegal (result 0, latency 1).
module alu_md
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_md_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_d;
  logic [4:0]         r_op;
  logic               r_mul_neg;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;       // {partial sum, remaining multiplier bits}
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_data;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_res;
  logic [WIDTH-1:0]   w_alu_res;
  logic [SHW-1:0]     w_shamt;
  logic               w_a_sgn;
  logic               w_b_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [2*WIDTH-1:0] w_prod_fin;
  logic [WIDTH-1:0]   w_mul_res;
  logic               w_mul_last;

  // Flush wins over a simultaneous request.
  assign w_accept = bus.i_valid & (r_state == StIdle) & ~bus.i_flush;
  assign w_is_mul = is_mul_op(bus.i_alu_op);
  assign w_shamt  = bus.i_operand_b[SHW-1:0];

  assign bus.o_ready    = (r_state == StIdle);
  assign bus.o_valid    = (r_state == StDone);
  assign bus.o_busy     = (r_state == StMul) | (r_state == StDiv);
  assign bus.o_alu_data = r_alu_data;

  // ---------------------------------------------------------------------------------------------
  // Single-cycle operations; anything not listed (including mul/div codes) yields 0 here.
  always_comb begin
    w_alu_res = ILLEGAL_RESULT[WIDTH-1:0];
    case (bus.i_alu_op)
      OpAdd:  w_alu_res = bus.i_operand_a + bus.i_operand_b;
      OpSub:  w_alu_res = bus.i_operand_a - bus.i_operand_b;
      OpSll:  w_alu_res = bus.i_operand_a << w_shamt;
      OpSlt:  w_alu_res = {{(WIDTH-1){1'b0}},
                           $signed(bus.i_operand_a) < $signed(bus.i_operand_b)};
      OpSltu: w_alu_res = {{(WIDTH-1){1'b0}}, bus.i_operand_a < bus.i_operand_b};
      OpXor:  w_alu_res = bus.i_operand_a ^ bus.i_operand_b;
      OpSrl:  w_alu_res = bus.i_operand_a >> w_shamt;
      OpSra:  w_alu_res = $signed(bus.i_operand_a) >>> w_shamt;
      OpOr:   w_alu_res = bus.i_operand_a | bus.i_operand_b;
      OpAnd:  w_alu_res = bus.i_operand_a & bus.i_operand_b;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Multiplier: unsigned shift-add on magnitudes, sign applied to the full 2*WIDTH product.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (bus.i_alu_op)
      OpMulh: begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
      end
      OpMulhsu: w_a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_sgn & bus.i_operand_a[WIDTH-1];
  assign w_b_neg = w_b_sgn & bus.i_operand_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -bus.i_operand_a : bus.i_operand_a;
  assign w_mag_b = w_b_neg ? -bus.i_operand_b : bus.i_operand_b;

  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_prod_fin  = r_mul_neg ? -w_prod_next : w_prod_next;
  assign w_mul_res   = (r_op == OpMul) ? w_prod_fin[WIDTH-1:0] : w_prod_fin[2*WIDTH-1:WIDTH];
  assign w_mul_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------------------------
  // Divider
`ifdef ALU_MD_DIV_EN
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_is_div = is_div_op(bus.i_alu_op);

  alu_md_div #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_accept & w_is_div),
    .i_flush     (bus.i_flush),
    .i_signed    ((bus.i_alu_op == OpDiv) | (bus.i_alu_op == OpRem)),
    .i_dividend  (bus.i_operand_a),
    .i_divisor   (bus.i_operand_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_div_res = ((r_op == OpRem) | (r_op == OpRemu)) ? w_rem : w_quo;
`else
  assign w_is_div   = 1'b0;
  assign w_div_done = 1'b0;
  assign w_div_res  = ILLEGAL_RESULT[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_d = StMul;
          end else if (w_is_div) begin
            w_state_d = StDiv;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StMul:   if (w_mul_last) w_state_d = StDone;
      StDiv:   if (w_div_done) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (bus.i_flush) begin
      w_state_d = StIdle;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath registers. o_alu_data only changes on the edge that enters DONE, so it holds
  // between result pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= '0;
      r_mul_neg  <= 1'b0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_alu_data <= '0;
    end else if (bus.i_flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= bus.i_alu_op;
            r_cnt <= '0;
            if (w_is_mul) begin
              r_mcand   <= w_mag_a;
              r_prod    <= {{WIDTH{1'b0}}, w_mag_b};
              r_mul_neg <= w_a_neg ^ w_b_neg;
            end else if (!w_is_div) begin
              r_alu_data <= w_alu_res;
            end
          end
        end
        StMul: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_alu_data <= w_mul_res;
          end
        end
        StDiv: begin
          if (w_div_done) begin
            r_alu_data <= w_div_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
